// File: rtl/pkt_wr_dispatch_pkg.sv
// Shared definitions for the packet write dispatcher and its FIFO read-side neighbour.
// Holds the state encodings, default sizing, and a saturating counter increment.
package pkt_wr_dispatch_pkg;

  localparam int unsigned NUM_SW_INST = 5;
  localparam int unsigned W_WIDTH     = 8;
  localparam int unsigned CNT_WIDTH   = 16;
  localparam logic [7:0]  ADDR_BASE   = 8'h10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pkt_wr_dispatch_if.sv
// Stream-in / FIFO-write bundle between the unit input port, the dispatcher and the switch FIFOs.
// The slave modport is the dispatcher's view.
interface pkt_wr_dispatch_if #(
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned NUM_SW_INST = 5
);
  logic [W_WIDTH-1:0]     data_in;
  logic                   valid_in;
  logic                   sop_in;
  logic                   eop_in;
  logic                   ready_out;
  logic [NUM_SW_INST-1:0] afull;
  logic [NUM_SW_INST-1:0] wr_en;
  logic [W_WIDTH-1:0]     wr_data;

  modport slave (
    input  data_in, valid_in, sop_in, eop_in, afull,
    output ready_out, wr_en, wr_data
  );

  modport master (
    output data_in, valid_in, sop_in, eop_in, afull,
    input  ready_out, wr_en, wr_data
  );
endinterface

// File: rtl/pkt_wr_dispatch_addr_match.sv
// Header-byte decoder: maps an address onto a switch index, with no wrap below ADDR_BASE.
// Also used by the unit-level address decoder.
module addr_match
  import pkt_wr_dispatch_pkg::*;
#(
  parameter int unsigned          W_WIDTH     = pkt_wr_dispatch_pkg::W_WIDTH,
  parameter int unsigned          NUM_SW_INST = pkt_wr_dispatch_pkg::NUM_SW_INST,
  parameter logic [W_WIDTH-1:0]   ADDR_BASE   = pkt_wr_dispatch_pkg::ADDR_BASE,
  parameter int unsigned          IDX_W       = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
  input  logic [W_WIDTH-1:0] hdr,
  output logic               hit,
  output logic [IDX_W-1:0]   hdr_idx
);

  logic [W_WIDTH-1:0] offs;

  always_comb begin
    offs    = hdr - ADDR_BASE;
    hit     = (hdr >= ADDR_BASE) && (offs < W_WIDTH'(NUM_SW_INST));
    hdr_idx = offs[IDX_W-1:0];
  end

endmodule

// File: rtl/pkt_wr_dispatch.sv
// Packet write dispatcher: routes each framed packet to the switch FIFO owning its header address,
// drops unknown-address packets, and reports framing errors.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | waiting for a header beat (sop)
// FWD     | forwarding payload to latched dest
// DROP    | discarding payload of a bad-address packet
module pkt_wr_dispatch
  import pkt_wr_dispatch_pkg::*;
#(
  parameter int unsigned        NUM_SW_INST = pkt_wr_dispatch_pkg::NUM_SW_INST,
  parameter int unsigned        W_WIDTH     = pkt_wr_dispatch_pkg::W_WIDTH,
  parameter logic [W_WIDTH-1:0] ADDR_BASE   = pkt_wr_dispatch_pkg::ADDR_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_wr_dispatch_if.slave     bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 proto_err
);

  localparam int unsigned IDX_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       dest_q, dest_d;
  logic [NUM_SW_INST-1:0] wr_en_q, wr_en_d;
  logic [W_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                   proto_err_q, proto_err_d;

  logic             hit;
  logic [IDX_W-1:0] hdr_idx;
  logic             ready;
  logic             beat;

  addr_match #(
    .W_WIDTH     (W_WIDTH),
    .NUM_SW_INST (NUM_SW_INST),
    .ADDR_BASE   (ADDR_BASE),
    .IDX_W       (IDX_W)
  ) u_addr_match (
    .hdr     (bus.data_in),
    .hit     (hit),
    .hdr_idx (hdr_idx)
  );

  // A sop beat is always gated by the FIFO it will land in, even when it truncates
  // a packet in FWD/DROP, so a restarted header can never overrun a full FIFO.
  always_comb begin
    ready = 1'b1;
    if (bus.sop_in) begin
      if (hit) ready = !bus.afull[hdr_idx];
    end else if (state_q == ST_FWD) begin
      ready = !bus.afull[dest_q];
    end
  end

  assign beat = bus.valid_in && ready;

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    wr_en_d     = '0;
    wr_data_d   = wr_data_q;
    drop_cnt_d  = drop_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    proto_err_d = 1'b0;

    if (beat) begin
      if (bus.sop_in) begin
        if (state_q == ST_FWD) begin
          proto_err_d = 1'b1;
          pkt_cnt_d   = sat_inc(pkt_cnt_d);
        end else if (state_q == ST_DROP) begin
          proto_err_d = 1'b1;
          drop_cnt_d  = sat_inc(drop_cnt_d);
        end
        if (hit) begin
          dest_d           = hdr_idx;
          wr_en_d[hdr_idx] = 1'b1;
          wr_data_d        = bus.data_in;
          if (bus.eop_in) begin
            pkt_cnt_d = sat_inc(pkt_cnt_d);
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_FWD;
          end
        end else if (bus.eop_in) begin
          drop_cnt_d = sat_inc(drop_cnt_d);
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_DROP;
        end
      end else begin
        case (state_q)
          ST_FWD: begin
            wr_en_d[dest_q] = 1'b1;
            wr_data_d       = bus.data_in;
            if (bus.eop_in) begin
              pkt_cnt_d = sat_inc(pkt_cnt_d);
              state_d   = ST_IDLE;
            end
          end
          ST_DROP: begin
            if (bus.eop_in) begin
              drop_cnt_d = sat_inc(drop_cnt_d);
              state_d    = ST_IDLE;
            end
          end
          default: proto_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      drop_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.ready_out = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign drop_cnt      = drop_cnt_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign proto_err     = proto_err_q;

endmodule
